// File: rtl/crddrop_stream_arb.sv
// Round-robin stream arbiter in front of one shared 2-lane crddrop datapath.
// Whole streams are granted at a time; an in-order owner queue steers datapath outputs back.

module crddrop_stream_arb_lane #(
  parameter int DATA_W   = 16,
  parameter int STOP_LSB = 8
) (
  input  logic                 in_act_i,
  input  logic                 grant_i,
  input  logic [1:0][DATA_W:0] rin_i,
  input  logic [1:0]           rin_vld_i,
  output logic [1:0]           rin_rdy_o,
  output logic [DATA_W:0]      dp_in_o,
  output logic                 dp_in_vld_o,
  input  logic                 dp_in_rdy_i,
  output logic                 in_tok_o,
  input  logic                 out_act_i,
  input  logic                 owner_i,
  input  logic [DATA_W:0]      dp_out_i,
  input  logic                 dp_out_vld_i,
  output logic                 dp_out_rdy_o,
  output logic [1:0]           rout_vld_o,
  input  logic [1:0]           rout_rdy_i,
  output logic                 out_tok_o
);
  function automatic logic is_done(input logic [DATA_W:0] p);
    return p[DATA_W] && (p[STOP_LSB+1:STOP_LSB] == 2'b01);
  endfunction

  always_comb begin
    rin_rdy_o    = '0;
    rout_vld_o   = '0;
    dp_in_o      = rin_i[grant_i];
    dp_in_vld_o  = in_act_i & rin_vld_i[grant_i];
    dp_out_rdy_o = out_act_i & rout_rdy_i[owner_i];
    if (in_act_i)  rin_rdy_o[grant_i]  = dp_in_rdy_i;
    if (out_act_i) rout_vld_o[owner_i] = dp_out_vld_i;
  end

  // act inputs already carry clk_en, so valid&ready here is a real transfer
  assign in_tok_o  = dp_in_vld_o & dp_in_rdy_i & is_done(dp_in_o);
  assign out_tok_o = dp_out_vld_i & dp_out_rdy_o & is_done(dp_out_i);
endmodule

module crddrop_stream_arb #(
  parameter int DATA_W     = 16,
  parameter int STOP_LSB   = 8,
  parameter int OWNQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [DATA_W:0] req0_in_0,
  input  logic            req0_in_0_valid,
  output logic            req0_in_0_ready,
  input  logic [DATA_W:0] req0_in_1,
  input  logic            req0_in_1_valid,
  output logic            req0_in_1_ready,
  input  logic [DATA_W:0] req1_in_0,
  input  logic            req1_in_0_valid,
  output logic            req1_in_0_ready,
  input  logic [DATA_W:0] req1_in_1,
  input  logic            req1_in_1_valid,
  output logic            req1_in_1_ready,
  output logic [DATA_W:0] dp_in_0,
  output logic            dp_in_0_valid,
  input  logic            dp_in_0_ready,
  output logic [DATA_W:0] dp_in_1,
  output logic            dp_in_1_valid,
  input  logic            dp_in_1_ready,
  input  logic [DATA_W:0] dp_out_0,
  input  logic            dp_out_0_valid,
  output logic            dp_out_0_ready,
  input  logic [DATA_W:0] dp_out_1,
  input  logic            dp_out_1_valid,
  output logic            dp_out_1_ready,
  output logic [DATA_W:0] req0_out_0,
  output logic            req0_out_0_valid,
  input  logic            req0_out_0_ready,
  output logic [DATA_W:0] req0_out_1,
  output logic            req0_out_1_valid,
  input  logic            req0_out_1_ready,
  output logic [DATA_W:0] req1_out_0,
  output logic            req1_out_0_valid,
  input  logic            req1_out_0_ready,
  output logic [DATA_W:0] req1_out_1,
  output logic            req1_out_1_valid,
  input  logic            req1_out_1_ready,
  output logic            busy,
  output logic            grant_id
);
  localparam int PTR_W = $clog2(OWNQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCK} state_e;

  // lane-major packing: [k][r]
  logic [1:0][1:0][DATA_W:0] rin;
  logic [1:0][1:0]           rin_vld, rin_rdy, rout_vld, rout_rdy;
  logic [1:0][DATA_W:0]      dp_in, dp_out;
  logic [1:0]                dp_in_vld, dp_in_rdy, dp_out_vld, dp_out_rdy;
  logic [1:0]                in_act, out_act, in_tok, out_tok, cand;

  state_e                  state_q, state_d;
  logic                    rr_q, rr_d, grant_q, grant_d, pick, owner, full, push, pop;
  logic [1:0]              in_done_q, in_done_d, out_done_q, out_done_d;
  logic [OWNQ_DEPTH-1:0]   ownq_q;
  logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  assign rin[0]     = {req1_in_0, req0_in_0};
  assign rin[1]     = {req1_in_1, req0_in_1};
  assign rin_vld[0] = {req1_in_0_valid, req0_in_0_valid};
  assign rin_vld[1] = {req1_in_1_valid, req0_in_1_valid};
  assign {req1_in_0_ready, req0_in_0_ready} = rin_rdy[0];
  assign {req1_in_1_ready, req0_in_1_ready} = rin_rdy[1];
  assign {dp_in_1, dp_in_0}             = dp_in;
  assign {dp_in_1_valid, dp_in_0_valid} = dp_in_vld;
  assign dp_in_rdy  = {dp_in_1_ready, dp_in_0_ready};
  assign dp_out     = {dp_out_1, dp_out_0};
  assign dp_out_vld = {dp_out_1_valid, dp_out_0_valid};
  assign {dp_out_1_ready, dp_out_0_ready} = dp_out_rdy;
  assign rout_rdy[0] = {req1_out_0_ready, req0_out_0_ready};
  assign rout_rdy[1] = {req1_out_1_ready, req0_out_1_ready};
  assign {req1_out_0_valid, req0_out_0_valid} = rout_vld[0];
  assign {req1_out_1_valid, req0_out_1_valid} = rout_vld[1];
  assign req0_out_0 = dp_out_0;
  assign req1_out_0 = dp_out_0;
  assign req0_out_1 = dp_out_1;
  assign req1_out_1 = dp_out_1;

  assign cand    = rin_vld[0] | rin_vld[1];
  assign pick    = cand[rr_q] ? rr_q : ~rr_q;
  assign full    = (cnt_q == CNT_W'(OWNQ_DEPTH));
  assign owner   = ownq_q[rd_q];
  assign in_act  = {2{clk_en && state_q == LOCK}} & ~in_done_q;
  assign out_act = {2{clk_en && cnt_q != '0}} & ~out_done_q;

  for (genvar k = 0; k < 2; k++) begin : g_lane
    crddrop_stream_arb_lane #(.DATA_W(DATA_W), .STOP_LSB(STOP_LSB)) u_lane (
      .in_act_i    (in_act[k]),
      .grant_i     (grant_q),
      .rin_i       (rin[k]),
      .rin_vld_i   (rin_vld[k]),
      .rin_rdy_o   (rin_rdy[k]),
      .dp_in_o     (dp_in[k]),
      .dp_in_vld_o (dp_in_vld[k]),
      .dp_in_rdy_i (dp_in_rdy[k]),
      .in_tok_o    (in_tok[k]),
      .out_act_i   (out_act[k]),
      .owner_i     (owner),
      .dp_out_i    (dp_out[k]),
      .dp_out_vld_i(dp_out_vld[k]),
      .dp_out_rdy_o(dp_out_rdy[k]),
      .rout_vld_o  (rout_vld[k]),
      .rout_rdy_i  (rout_rdy[k]),
      .out_tok_o   (out_tok[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    in_done_d  = in_done_q;
    out_done_d = out_done_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (clk_en) begin
      if (state_q == IDLE) begin
        if (|cand && !full) begin
          push    = 1'b1;
          grant_d = pick;
          state_d = LOCK;
        end
      end else begin
        in_done_d = in_done_q | in_tok;
        if (&in_done_d) begin
          in_done_d = '0;
          rr_d      = ~grant_q;
          state_d   = IDLE;
        end
      end
      out_done_d = out_done_q | out_tok;
      if (&out_done_d) begin
        out_done_d = '0;
        pop        = 1'b1;
        rd_d       = rd_q + PTR_W'(1);
      end
      if (push) wr_d = wr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      grant_q    <= 1'b0;
      in_done_q  <= '0;
      out_done_q <= '0;
      ownq_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      in_done_q  <= in_done_d;
      out_done_q <= out_done_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      if (push) ownq_q[wr_q] <= pick;
    end
  end

  assign busy     = (state_q == LOCK) || (cnt_q != '0);
  assign grant_id = grant_q;
endmodule

// File: tb/tb_crddrop_stream_arb.sv
// Bench for crddrop_stream_arb: an identity datapath model plus per-requester/lane scoreboards.
module tb_crddrop_stream_arb;
  localparam int PW = 17;

  logic clk = 1'b0;
  logic rst_n, clk_en;
  logic [PW-1:0] rin [2][2];
  logic          rin_v [2][2];
  logic          rin_r [2][2];
  logic [PW-1:0] dpi [2];
  logic          dpi_v [2];
  logic          dpi_r [2];
  logic [PW-1:0] dpo [2];
  logic          dpo_v [2];
  logic          dpo_r [2];
  logic [PW-1:0] rout [2][2];
  logic          rout_v [2][2];
  logic          rout_r [2][2];
  logic          busy, grant_id;

  // bench models: sources, datapath FIFO per lane, expected outputs per requester/lane
  logic [PW-1:0] src [4][$];
  logic [PW-1:0] sb  [4][$];
  logic [PW-1:0] dpq [2][$];
  int            grant_log [$];
  logic          dpi_ctl [2];
  logic          rout_ctl [2][2];
  logic          fire_in [2][2];
  logic          stl [2][2];
  logic          tok [2];
  logic          seen [2];
  logic          new_stream, any_fire, busy_s;
  logic [11:0]   ov_s;
  int            errors, checks;

  always #5 clk = ~clk;

  crddrop_stream_arb dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req0_in_0(rin[0][0]), .req0_in_0_valid(rin_v[0][0]), .req0_in_0_ready(rin_r[0][0]),
    .req0_in_1(rin[0][1]), .req0_in_1_valid(rin_v[0][1]), .req0_in_1_ready(rin_r[0][1]),
    .req1_in_0(rin[1][0]), .req1_in_0_valid(rin_v[1][0]), .req1_in_0_ready(rin_r[1][0]),
    .req1_in_1(rin[1][1]), .req1_in_1_valid(rin_v[1][1]), .req1_in_1_ready(rin_r[1][1]),
    .dp_in_0(dpi[0]), .dp_in_0_valid(dpi_v[0]), .dp_in_0_ready(dpi_r[0]),
    .dp_in_1(dpi[1]), .dp_in_1_valid(dpi_v[1]), .dp_in_1_ready(dpi_r[1]),
    .dp_out_0(dpo[0]), .dp_out_0_valid(dpo_v[0]), .dp_out_0_ready(dpo_r[0]),
    .dp_out_1(dpo[1]), .dp_out_1_valid(dpo_v[1]), .dp_out_1_ready(dpo_r[1]),
    .req0_out_0(rout[0][0]), .req0_out_0_valid(rout_v[0][0]), .req0_out_0_ready(rout_r[0][0]),
    .req0_out_1(rout[0][1]), .req0_out_1_valid(rout_v[0][1]), .req0_out_1_ready(rout_r[0][1]),
    .req1_out_0(rout[1][0]), .req1_out_0_valid(rout_v[1][0]), .req1_out_0_ready(rout_r[1][0]),
    .req1_out_1(rout[1][1]), .req1_out_1_valid(rout_v[1][1]), .req1_out_1_ready(rout_r[1][1]),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic is_done(input logic [PW-1:0] p);
    return p[16] && (p[9:8] == 2'b01);
  endfunction
  function automatic logic [PW-1:0] dat(input int v);
    return {1'b0, 16'(v)};
  endfunction
  function automatic logic [PW-1:0] done_tok(input int t);
    return {1'b1, 6'd0, 2'b01, 8'(t)};
  endfunction
  function automatic logic [PW-1:0] eos0(input int t);
    return {1'b1, 6'd0, 2'b00, 8'(t)};
  endfunction
  function automatic logic [11:0] outs();
    return {rin_r[0][0], rin_r[0][1], rin_r[1][0], rin_r[1][1], dpi_v[0], dpi_v[1],
            dpo_r[0], dpo_r[1], rout_v[0][0], rout_v[0][1], rout_v[1][0], rout_v[1][1]};
  endfunction
  function automatic int sb_total();
    int n = 0;
    for (int i = 0; i < 4; i++) n += sb[i].size();
    return n;
  endfunction
  function automatic logic models_empty();
    int n = dpq[0].size() + dpq[1].size();
    for (int i = 0; i < 4; i++) n += src[i].size();
    return n == 0;
  endfunction

  task automatic push_pkt(input int r, input int k, input logic [PW-1:0] p);
    src[r*2+k].push_back(p);
    sb[r*2+k].push_back(p);
  endtask

  task automatic load_stream(input int r, input int n0, input int n1, input int tag);
    for (int i = 0; i < n0; i++) push_pkt(r, 0, dat(tag*256 + i));
    push_pkt(r, 0, done_tok(tag));
    for (int i = 0; i < n1; i++) push_pkt(r, 1, dat(tag*256 + 128 + i));
    push_pkt(r, 1, done_tok(tag));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin src[i].delete(); sb[i].delete(); end
    for (int k = 0; k < 2; k++) begin
      dpq[k].delete(); dpi_ctl[k] = 1'b1; seen[k] = 1'b0; dpo_v[k] = 1'b0; dpi_r[k] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        rout_ctl[r][k] = 1'b1; rin_v[r][k] = 1'b0; rout_r[r][k] = 1'b0;
      end
    end
    grant_log.delete();
    new_stream = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, settle, account transfers that commit at the next posedge.
  task automatic step();
    int nf, fr, nr;
    logic dfire, ofire;
    logic [PW-1:0] e;
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        rin_v[r][k]  = (src[r*2+k].size() != 0);
        rin[r][k]    = rin_v[r][k] ? src[r*2+k][0] : '0;
        rout_r[r][k] = rout_ctl[r][k];
      end
    for (int k = 0; k < 2; k++) begin
      dpi_r[k] = dpi_ctl[k];
      dpo_v[k] = (dpq[k].size() != 0);
      dpo[k]   = dpo_v[k] ? dpq[k][0] : '0;
    end
    #1;
    any_fire = 1'b0;
    ov_s     = outs();
    busy_s   = busy;
    for (int k = 0; k < 2; k++) begin
      nf = 0; fr = 0; tok[k] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        stl[r][k]     = rin_v[r][k] & ~rin_r[r][k];
        fire_in[r][k] = rin_v[r][k] & rin_r[r][k] & clk_en;
        if (fire_in[r][k]) begin nf++; fr = r; any_fire = 1'b1; end
      end
      dfire = dpi_v[k] & dpi_r[k] & clk_en;
      checks++;
      if (nf != int'(dfire) || (dfire && (dpi[k] !== rin[fr][k] || grant_id !== 1'(fr)))) begin
        errors++;
        $display("FAIL dp_in_fwd lane%0d: got fire=%0b data=%h grant=%0d, expected fire=%0d data=%h grant=%0d",
                 k, dfire, dpi[k], grant_id, nf, rin[fr][k], fr);
      end
      if (dfire) begin
        if (new_stream) begin grant_log.push_back(int'(grant_id)); new_stream = 1'b0; end
        dpq[k].push_back(dpi[k]);
        if (is_done(dpi[k])) begin tok[k] = 1'b1; seen[k] = 1'b1; end
      end
      for (int r = 0; r < 2; r++) if (fire_in[r][k]) void'(src[r*2+k].pop_front());
    end
    if (seen[0] && seen[1]) begin new_stream = 1'b1; seen[0] = 1'b0; seen[1] = 1'b0; end
    for (int k = 0; k < 2; k++) begin
      ofire = dpo_v[k] & dpo_r[k] & clk_en;
      nr = 0;
      for (int r = 0; r < 2; r++)
        if (rout_v[r][k] & rout_r[r][k] & clk_en) begin
          nr++;
          checks++;
          if (sb[r*2+k].size() == 0) begin
            errors++;
            $display("FAIL req_out_unexpected r%0d lane%0d: got %h, expected no packet", r, k, rout[r][k]);
          end else begin
            e = sb[r*2+k].pop_front();
            if (rout[r][k] !== e) begin
              errors++;
              $display("FAIL req_out_data r%0d lane%0d: got %h, expected %h", r, k, rout[r][k], e);
            end
          end
        end
      checks++;
      if (nr != int'(ofire)) begin
        errors++;
        $display("FAIL dp_out_steer lane%0d: got %0d req_out transfers, expected %0d", k, nr, ofire);
      end
      if (ofire) void'(dpq[k].pop_front());
    end
    @(posedge clk);
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    do begin step(); n++; end while (!(busy_s == 1'b0 && models_empty()) && n < bound);
    checks++;
    if (!(busy_s == 1'b0 && models_empty())) begin
      errors++;
      $display("FAIL drain_timeout: got busy=%0b after %0d cycles, expected idle", busy_s, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clk_en = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dpi_r[k] = 1'b1; dpo_v[k] = 1'b1; dpo[k] = '0;
      for (int r = 0; r < 2; r++) begin rin_v[r][k] = 1'b1; rin[r][k] = '0; rout_r[r][k] = 1'b1; end
    end
    #1;
    checks++;
    if (outs() !== 12'h0) begin errors++; $display("FAIL reset_hs: got %b, expected 0", outs()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b, expected 0", grant_id); end
    apply_reset();
    step();
    checks++;
    if (busy_s !== 1'b0 || any_fire) begin
      errors++; $display("FAIL reset_idle: got busy=%b fire=%b, expected 0/0", busy_s, any_fire);
    end
  endtask

  task automatic test_single();
    apply_reset();
    push_pkt(0, 0, dat(5)); push_pkt(0, 0, dat(7)); push_pkt(0, 0, eos0(1)); push_pkt(0, 0, done_tok(2));
    push_pkt(0, 1, dat(9)); push_pkt(0, 1, done_tok(3));
    step();
    checks++;
    if (any_fire) begin errors++; $display("FAIL idle_no_fwd: got transfer in IDLE, expected none"); end
    step();
    checks++;
    if (!(fire_in[0][0] && fire_in[0][1])) begin
      errors++; $display("FAIL first_fwd: got %b%b, expected 11", fire_in[0][0], fire_in[0][1]);
    end
    run_until_idle(100);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      errors++; $display("FAIL single_grant: got n=%0d, expected one grant to 0", grant_log.size());
    end
    checks++;
    if (sb_total() != 0) begin errors++; $display("FAIL single_drain: got %0d left, expected 0", sb_total()); end
  endtask

  task automatic test_rr();
    int order [4] = '{0, 1, 0, 1};
    apply_reset();
    load_stream(0, 2, 1, 16'h10); load_stream(1, 1, 2, 16'h20);
    load_stream(0, 1, 1, 16'h30); load_stream(1, 2, 2, 16'h40);
    run_until_idle(200);
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d, expected 4", grant_log.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != order[i]) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, grant_log[i], order[i]);
        end
      end
    checks++;
    if (sb_total() != 0) begin errors++; $display("FAIL rr_drain: got %0d left, expected 0", sb_total()); end
  endtask

  task automatic test_lane_skew();
    int c0 = -1, c1 = -1, stalls = 0;
    logic af [16];
    logic f0 [16];
    apply_reset();
    push_pkt(0, 0, dat(1)); push_pkt(0, 0, done_tok(5));
    for (int i = 0; i < 7; i++) push_pkt(0, 1, dat(16'h100 + i));
    push_pkt(0, 1, done_tok(6));
    load_stream(0, 1, 1, 16'h50);
    for (int c = 0; c < 16; c++) begin
      step();
      af[c] = any_fire;
      f0[c] = fire_in[0][0];
      if (c0 >= 0 && c1 < 0 && stl[0][0]) stalls++;
      if (tok[0] && c0 < 0) c0 = c;
      if (tok[1] && c1 < 0) c1 = c;
    end
    checks++;
    if (c0 < 0 || c1 - c0 != 6) begin errors++; $display("FAIL skew_gap: got c0=%0d c1=%0d, expected gap 6", c0, c1); end
    checks++;
    if (stalls != 6) begin errors++; $display("FAIL skew_stall: got %0d, expected 6", stalls); end
    checks++;
    if (c1 < 0 || c1 > 13) begin
      errors++; $display("FAIL skew_done: got c1=%0d, expected 8", c1);
    end else if (af[c1+1] || !f0[c1+2]) begin
      errors++; $display("FAIL skew_bubble: got idle_fire=%b next_fire=%b, expected 0/1", af[c1+1], f0[c1+2]);
    end
    run_until_idle(100);
    checks++;
    if (sb_total() != 0) begin errors++; $display("FAIL skew_drain: got %0d left, expected 0", sb_total()); end
  endtask

  task automatic test_ownq_full();
    apply_reset();
    for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) rout_ctl[r][k] = 1'b0;
    for (int i = 0; i < 5; i++) load_stream(i % 2, 1, 1, 16'h60 + i);
    repeat (40) step();
    checks++;
    if (grant_log.size() != 4) begin errors++; $display("FAIL ownq_grants: got %0d, expected 4", grant_log.size()); end
    checks++;
    if (src[0].size() != 2 || !stl[0][0] || busy_s !== 1'b1) begin
      errors++; $display("FAIL ownq_hold: got left=%0d stall=%b busy=%b, expected 2/1/1", src[0].size(), stl[0][0], busy_s);
    end
    for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) rout_ctl[r][k] = 1'b1;
    run_until_idle(200);
    checks++;
    if (grant_log.size() != 5) begin errors++; $display("FAIL ownq_final: got %0d, expected 5", grant_log.size()); end
    checks++;
    if (sb_total() != 0) begin errors++; $display("FAIL ownq_drain: got %0d left, expected 0", sb_total()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    apply_reset();
    load_stream(0, 4, 3, 16'h70); load_stream(1, 3, 5, 16'h71); load_stream(0, 2, 2, 16'h72);
    do begin
      dpi_ctl[0] = (n % 2 == 0);
      for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) rout_ctl[r][k] = !(n >= 6 && n < 9);
      step();
      n++;
    end while (!(busy_s == 1'b0 && models_empty()) && n < 400);
    checks++;
    if (n >= 400) begin errors++; $display("FAIL bp_timeout: got busy=%b, expected idle", busy_s); end
    checks++;
    if (sb_total() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, expected 0", sb_total()); end
    checks++;
    if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0) begin
      errors++; $display("FAIL bp_order: got n=%0d, expected 0,1,0", grant_log.size());
    end
  endtask

  task automatic test_clk_en();
    apply_reset();
    load_stream(1, 3, 3, 16'h80);
    repeat (3) step();
    clk_en = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (any_fire || ov_s !== 12'h0) begin
        errors++; $display("FAIL clk_en_gate: got fire=%b hs=%b, expected 0/0", any_fire, ov_s);
      end
    end
    clk_en = 1'b1;
    run_until_idle(100);
    checks++;
    if (sb_total() != 0 || grant_log.size() != 1 || grant_log[0] != 1) begin
      errors++; $display("FAIL clk_en_resume: got left=%0d grants=%0d, expected 0/1", sb_total(), grant_log.size());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_stream(1, 6, 6, 16'h90);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 12'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got hs=%b busy=%b, expected 0/0", outs(), busy);
    end
    apply_reset();
    load_stream(1, 1, 1, 16'h91);
    load_stream(0, 1, 1, 16'h92);
    run_until_idle(100);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0) begin
      errors++; $display("FAIL mid_reset_rr: got n=%0d, expected first grant 0 of 2", grant_log.size());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_rr();
    test_lane_skew();
    test_ownq_full();
    test_backpressure();
    test_clk_en();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
